mc_depacketizer: RTL and testbench
==================================

MC_DEPACKETIZER -- requirements
Module: mc_depacketizer

Interface
REQ-001 SHALL have parameter PAYLOAD_WIDTH, default 128, assembled payload width; must be a multiple of PACKET_WIDTH.
REQ-002 SHALL have parameter PACKET_WIDTH, default 16, link packet width.
REQ-003 SHALL have parameter N_CH, default 4, number of logical channels accepted.
REQ-004 SHALL have parameter CH_BITS, default 2, header channel-id field width; N_CH <= 2**CH_BITS.
REQ-005 SHALL have parameter N_PKTS_BITS, default 4, header length field width.
REQ-006 SHALL have parameter DEPTH, default 4, output FIFO entries (power of 2); DEPTH_LOG, default 2.
REQ-007 SHALL have parameter AF_LVL, default 1, free-entry threshold for packet_af_o.
REQ-008 SHALL have ports: clk input 1, the single clock; rst_n input 1, synchronous active-low reset.
REQ-009 SHALL have ports: packet_i input PACKET_WIDTH, header or data packet, one per clk; packet_af_o output 1, almost-full back-pressure to sender.
REQ-010 SHALL have ports: ch_en_i input N_CH, per-channel accept mask; err_clr_i input 1, clears err_o and drop_cnt_o.
REQ-011 SHALL have ports: payload_o output PAYLOAD_WIDTH; payload_ch_o output CH_BITS; payload_len_o output N_PKTS_BITS, data packets in payload.
REQ-012 SHALL have ports: payload_valid_o output 1; payload_ready_i input 1; valid/ready handshake, transfer when both high.
REQ-013 SHALL have ports: err_o output 1, sticky error; drop_cnt_o output 8, saturating count of dropped transactions.

Function
REQ-014 Header decode SHALL be: bit0 = valid, bits[CH_BITS:1] = chan, next N_PKTS_BITS bits = n; remaining bits ignored.
REQ-015 FSM SHALL have states IDLE, COLLECT, DROP; reset state IDLE.
REQ-016 In IDLE, a packet with valid=0 SHALL be ignored.
REQ-017 In IDLE, valid header with chan < N_CH, ch_en_i[chan]=1, and 1 <= n <= PAYLOAD_WIDTH/PACKET_WIDTH SHALL go to COLLECT with remaining count = n; the assembly register is cleared.
REQ-018 In IDLE, valid header failing REQ-017 with n != 0 SHALL go to DROP with remaining count = n, increment drop_cnt_o, and set err_o unless the only failure is ch_en_i[chan]=0.
REQ-019 In IDLE, valid header with n = 0 SHALL stay IDLE and set err_o.
REQ-020 In COLLECT, every cycle SHALL take packet_i as data packet k (k = 0..n-1) into payload bits [k*PACKET_WIDTH +: PACKET_WIDTH]; unwritten upper bits stay zero.
REQ-021 In DROP, every cycle SHALL discard packet_i; after n cycles the FSM returns to IDLE.
REQ-022 On the last data packet the FSM SHALL return to IDLE; a header on the very next cycle is accepted (zero bubble).
REQ-023 Completed {payload, chan, n} SHALL be pushed to the output FIFO at the clk edge ending the last data packet; payload_valid_o rises one cycle after the last data packet.
REQ-024 The FIFO SHALL present its head combinationally (first-word fall-through); payload_valid_o = not empty.
REQ-025 Push and pop on the same edge SHALL both take effect, including when full.
REQ-026 Push when full without a simultaneous pop SHALL drop the payload, set err_o, increment drop_cnt_o.
REQ-027 packet_af_o SHALL be high when free entries <= AF_LVL, or when free entries = AF_LVL + 1 and the FSM is in COLLECT.
REQ-028 drop_cnt_o SHALL saturate at 255.
REQ-029 err_clr_i SHALL clear err_o and drop_cnt_o on the next edge; a same-cycle new error wins (set / count = 1).
REQ-030 ch_en_i SHALL be sampled only at header decode; changes mid-transaction have no effect on that transaction.

Reset
REQ-031 rst_n = 0 at a clk edge SHALL force: FSM IDLE, remaining count 0, assembly register 0, FIFO empty, payload_valid_o 0, packet_af_o 0, err_o 0, drop_cnt_o 0.
REQ-032 Reset asserted mid-COLLECT SHALL discard the partial payload; no partial entry is ever pushed.
REQ-033 payload_o, payload_ch_o, payload_len_o SHALL read 0 while the FIFO is empty after reset.

Structure
REQ-034 Header field offsets, FSM state encodings, and the clog2 function SHALL live in shared serdes package/include serdes_pkg, shared with the packetizer.
REQ-035 The output FIFO SHALL be sub-module sync_fifo (parametrised width/depth, FWFT, count output); FSM and assembly logic stay in mc_depacketizer.

Verification
REQ-036 Header chan=1, n=8, ch_en_i=4'hF, data 16'h0001..16'h0008 -> payload_o = 128'h0008_0007_..._0001, payload_ch_o = 1, payload_len_o = 8, valid one cycle after last data.
REQ-037 Header chan=2, n=3, data A,B,C -> payload_o = {80'h0, C, B, A}, payload_len_o = 3; immediate next header accepted with no idle cycle.
REQ-038 Header chan=3 with ch_en_i[3]=0, n=4 -> 4 packets discarded, drop_cnt_o = 1, err_o = 0, FIFO untouched; header n=0 -> err_o = 1.
REQ-039 payload_ready_i=0, DEPTH=4, five back-to-back n=8 transactions -> packet_af_o high at 3 stored, fifth dropped, err_o = 1, drop_cnt_o = 1; ready=1 drains four in order.
REQ-040 FIFO full, ready=1 on the same edge as a completing push -> no drop, count stays 4.
REQ-041 rst_n=0 during packet 5 of 8 -> after release payload_valid_o = 0; next full transaction assembles correctly.

Source files
------------

// File: rtl/serdes_pkg.sv
// Shared definitions for the serdes packetizer/depacketizer pair:
// header field offsets, FSM state encoding and a constant clog2 helper.
package serdes_pkg;

    // Header layout: bit 0 valid, then channel id, then packet count.
    localparam int HDR_VALID_BIT = 0;
    localparam int HDR_CHAN_LSB  = 1;

    // The length field sits directly above the channel field.
    function automatic int hdr_len_lsb(input int ch_bits);
        return HDR_CHAN_LSB + ch_bits;
    endfunction

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_DROP    = 2'd2
    } fsm_state_t;

    // Ceiling log2 usable in constant expressions.
    function automatic int clog2(input int value);
        int result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) result = i + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO with occupancy count.
// A push while full is accepted only if a pop happens on the same edge.
module sync_fifo #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 4,
    parameter int DEPTH_LOG = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 push,
    input  logic [WIDTH-1:0]     push_data,
    input  logic                 pop,
    output logic [WIDTH-1:0]     head,
    output logic                 empty,
    output logic                 full,
    output logic [DEPTH_LOG:0]   count
);

    logic [WIDTH-1:0]     mem [DEPTH];
    logic [DEPTH_LOG-1:0] wr_ptr_reg;
    logic [DEPTH_LOG-1:0] rd_ptr_reg;
    logic [DEPTH_LOG:0]   count_reg;
    logic                 do_push;
    logic                 do_pop;

    assign empty   = (count_reg == '0);
    assign full    = (count_reg == (DEPTH_LOG+1)'(DEPTH));
    assign count   = count_reg;
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Head is shown combinationally; it reads zero whenever nothing is stored.
    assign head = empty ? '0 : mem[rd_ptr_reg];

    // Storage array: written only, never reset (contents qualified by count).
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_reg] <= push_data;
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/mc_depacketizer.sv
// Multi-channel depacketizer: decodes a header, gathers n data packets into
// a payload word and queues {payload, chan, n} in an output FIFO.
module mc_depacketizer
    import serdes_pkg::*;
#(
    parameter int PAYLOAD_WIDTH = 128,
    parameter int PACKET_WIDTH  = 16,
    parameter int N_CH          = 4,
    parameter int CH_BITS       = 2,
    parameter int N_PKTS_BITS   = 4,
    parameter int DEPTH         = 4,
    parameter int DEPTH_LOG     = 2,
    parameter int AF_LVL        = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [PACKET_WIDTH-1:0]  packet_i,
    output logic                     packet_af_o,
    input  logic [N_CH-1:0]          ch_en_i,
    input  logic                     err_clr_i,
    output logic [PAYLOAD_WIDTH-1:0] payload_o,
    output logic [CH_BITS-1:0]       payload_ch_o,
    output logic [N_PKTS_BITS-1:0]   payload_len_o,
    output logic                     payload_valid_o,
    input  logic                     payload_ready_i,
    output logic                     err_o,
    output logic [7:0]               drop_cnt_o
);

    localparam int MAX_PKTS = PAYLOAD_WIDTH / PACKET_WIDTH;
    localparam int K_W      = (MAX_PKTS > 1) ? clog2(MAX_PKTS) : 1;
    localparam int LEN_LSB  = hdr_len_lsb(CH_BITS);
    localparam int EN_W     = 1 << CH_BITS;
    localparam int ENTRY_W  = PAYLOAD_WIDTH + CH_BITS + N_PKTS_BITS;

    fsm_state_t               state_reg, state_next;
    logic [N_PKTS_BITS-1:0]   rem_reg, rem_next;
    logic [K_W-1:0]           idx_reg, idx_next;
    logic [CH_BITS-1:0]       chan_reg, chan_next;
    logic [N_PKTS_BITS-1:0]   len_reg, len_next;
    logic [PAYLOAD_WIDTH-1:0] asm_reg, asm_next, asm_merged;
    logic                     err_reg, err_next;
    logic [7:0]               cnt_reg, cnt_next;

    logic                     hdr_valid, chan_ok, len_ok, en_ok;
    logic [CH_BITS-1:0]       hdr_chan;
    logic [N_PKTS_BITS-1:0]   hdr_n;
    logic [EN_W-1:0]          en_ext;
    logic [MAX_PKTS-1:0]      slot_we;
    logic                     push, hdr_err, hdr_drop, fifo_drop;
    logic                     fifo_empty, fifo_full, fifo_pop;
    logic [DEPTH_LOG:0]       fifo_count;
    logic [ENTRY_W-1:0]       fifo_head;
    logic [31:0]              free_entries;
    logic                     unused_hdr_bits;

    // Header fields; bits above the length field carry no meaning.
    assign hdr_valid       = packet_i[HDR_VALID_BIT];
    assign hdr_chan        = packet_i[HDR_CHAN_LSB +: CH_BITS];
    assign hdr_n           = packet_i[LEN_LSB +: N_PKTS_BITS];
    assign unused_hdr_bits = ^packet_i[PACKET_WIDTH-1:LEN_LSB+N_PKTS_BITS];

    // Zero-extend the enable mask so any encodable channel id indexes safely.
    assign en_ext  = EN_W'(ch_en_i);
    assign chan_ok = (32'(hdr_chan) < 32'(N_CH));
    assign en_ok   = chan_ok && en_ext[hdr_chan];
    assign len_ok  = (hdr_n != '0) && (32'(hdr_n) <= 32'(MAX_PKTS));

    // Each payload slot takes packet_i only on its own collect cycle.
    genvar gi;
    generate
        for (gi = 0; gi < MAX_PKTS; gi++) begin : g_slot
            assign slot_we[gi] = (state_reg == ST_COLLECT) && (idx_reg == K_W'(gi));
            assign asm_merged[gi*PACKET_WIDTH +: PACKET_WIDTH] =
                slot_we[gi] ? packet_i : asm_reg[gi*PACKET_WIDTH +: PACKET_WIDTH];
        end
    endgenerate

    // Next-state and datapath control for header decode / collect / drop.
    always_comb begin
        state_next = state_reg;
        rem_next   = rem_reg;
        idx_next   = idx_reg;
        chan_next  = chan_reg;
        len_next   = len_reg;
        asm_next   = asm_reg;
        push       = 1'b0;
        hdr_err    = 1'b0;
        hdr_drop   = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (hdr_valid) begin
                    if (hdr_n == '0) begin
                        hdr_err = 1'b1;
                    end else if (chan_ok && len_ok && en_ok) begin
                        state_next = ST_COLLECT;
                        rem_next   = hdr_n;
                        idx_next   = '0;
                        chan_next  = hdr_chan;
                        len_next   = hdr_n;
                        asm_next   = '0;
                    end else begin
                        // A merely disabled channel is a silent drop, not an error.
                        state_next = ST_DROP;
                        rem_next   = hdr_n;
                        hdr_drop   = 1'b1;
                        hdr_err    = !(chan_ok && len_ok);
                    end
                end
            end
            ST_COLLECT: begin
                asm_next = asm_merged;
                idx_next = idx_reg + 1'b1;
                rem_next = rem_reg - 1'b1;
                if (rem_reg == N_PKTS_BITS'(1)) begin
                    push       = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            ST_DROP: begin
                rem_next = rem_reg - 1'b1;
                if (rem_reg == N_PKTS_BITS'(1)) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // FSM and assembly registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
            rem_reg   <= '0;
            idx_reg   <= '0;
            chan_reg  <= '0;
            len_reg   <= '0;
            asm_reg   <= '0;
        end else begin
            state_reg <= state_next;
            rem_reg   <= rem_next;
            idx_reg   <= idx_next;
            chan_reg  <= chan_next;
            len_reg   <= len_next;
            asm_reg   <= asm_next;
        end
    end

    assign fifo_pop  = payload_ready_i && !fifo_empty;
    assign fifo_drop = push && fifo_full && !fifo_pop;

    sync_fifo #(
        .WIDTH     (ENTRY_W),
        .DEPTH     (DEPTH),
        .DEPTH_LOG (DEPTH_LOG)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data ({asm_merged, chan_reg, len_reg}),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .empty     (fifo_empty),
        .full      (fifo_full),
        .count     (fifo_count)
    );

    assign {payload_o, payload_ch_o, payload_len_o} = fifo_head;
    assign payload_valid_o = !fifo_empty;

    // Warn one transaction early while a payload is still being gathered.
    assign free_entries = 32'(DEPTH) - 32'(fifo_count);
    assign packet_af_o  = (free_entries <= 32'(AF_LVL)) ||
                          ((free_entries == 32'(AF_LVL) + 32'd1) && (state_reg == ST_COLLECT));

    // Sticky error and saturating drop counter; a fresh event beats a clear.
    always_comb begin
        err_next = err_reg;
        cnt_next = cnt_reg;
        if (hdr_err || fifo_drop) err_next = 1'b1;
        else if (err_clr_i)       err_next = 1'b0;
        if (hdr_drop || fifo_drop) begin
            if (err_clr_i)             cnt_next = 8'd1;
            else if (cnt_reg != 8'hFF) cnt_next = cnt_reg + 8'd1;
        end else if (err_clr_i) begin
            cnt_next = 8'd0;
        end
    end

    // Error status registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_reg <= 1'b0;
            cnt_reg <= 8'd0;
        end else begin
            err_reg <= err_next;
            cnt_reg <= cnt_next;
        end
    end

    assign err_o      = err_reg;
    assign drop_cnt_o = cnt_reg;

endmodule

// File: tb/tb_mc_depacketizer.sv
// Self-checking bench for mc_depacketizer: per-cycle comparison against a
// transaction-level model, a table of single-header cases, directed corner
// sequences and a randomized soak.
module tb_mc_depacketizer;

    localparam int PW = 128, KW = 16, N_CH = 4, CH_BITS = 2, NB = 4;
    localparam int DEPTH = 4, DEPTH_LOG = 2, AF_LVL = 1, MAXP = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [15:0]  packet;
    logic [3:0]   ch_en;
    logic         err_clr;
    logic         ready;
    logic         af;
    logic [127:0] payload;
    logic [1:0]   pay_ch;
    logic [3:0]   pay_len;
    logic         pay_valid;
    logic         err;
    logic [7:0]   drop_cnt;

    always #5 clk = ~clk;

    mc_depacketizer #(
        .PAYLOAD_WIDTH (PW), .PACKET_WIDTH (KW), .N_CH (N_CH), .CH_BITS (CH_BITS),
        .N_PKTS_BITS (NB), .DEPTH (DEPTH), .DEPTH_LOG (DEPTH_LOG), .AF_LVL (AF_LVL)
    ) dut (
        .clk (clk), .rst_n (rst_n), .packet_i (packet), .packet_af_o (af),
        .ch_en_i (ch_en), .err_clr_i (err_clr), .payload_o (payload),
        .payload_ch_o (pay_ch), .payload_len_o (pay_len), .payload_valid_o (pay_valid),
        .payload_ready_i (ready), .err_o (err), .drop_cnt_o (drop_cnt)
    );

    typedef struct {
        logic [127:0] payload;
        logic [1:0]   ch;
        logic [3:0]   len;
    } entry_t;

    // Reference model state: a queue of finished transactions plus the
    // packets gathered so far for the transaction in flight.
    entry_t      m_fifo[$];
    logic [15:0] m_pkts[$];
    int          m_rem;
    bit          m_collect;
    logic [1:0]  m_chan;
    logic [3:0]  m_len;
    bit          m_err;
    int          m_cnt;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] hdr(input int ch, input int n);
        return 16'(((n & 15) << 3) | ((ch & 3) << 1) | 1);
    endfunction

    function automatic logic [15:0] data_for(input int t, input int k);
        return {8'(t + 16), 8'(k)};
    endfunction

    function automatic logic [127:0] payload_for(input int t);
        logic [127:0] p = '0;
        for (int k = 0; k < 8; k++) p[k*16 +: 16] = data_for(t, k);
        return p;
    endfunction

    // Apply one clock edge to the model using the inputs present at that edge.
    function automatic void model_edge();
        bit     pop, push, err_ev, drop_ev;
        entry_t e;
        if (!rst_n) begin
            m_fifo.delete(); m_pkts.delete();
            m_rem = 0; m_collect = 0; m_err = 0; m_cnt = 0;
            return;
        end
        pop = ready && (m_fifo.size() > 0);
        push = 0; err_ev = 0; drop_ev = 0;
        e.payload = '0; e.ch = '0; e.len = '0;
        if (m_rem == 0) begin
            if (packet[0]) begin
                int ch, n;
                bit fmt_ok;
                ch = int'(packet[2:1]);
                n  = int'(packet[6:3]);
                fmt_ok = (ch < N_CH) && (n <= MAXP);
                if (n == 0) begin
                    err_ev = 1;
                end else if (fmt_ok && ch_en[ch]) begin
                    m_collect = 1; m_rem = n; m_pkts.delete();
                    m_chan = 2'(ch); m_len = 4'(n);
                end else begin
                    m_collect = 0; m_rem = n; drop_ev = 1;
                    if (!fmt_ok) err_ev = 1;
                end
            end
        end else begin
            if (m_collect) m_pkts.push_back(packet);
            m_rem--;
            if (m_rem == 0 && m_collect) begin
                foreach (m_pkts[k]) e.payload[k*16 +: 16] = m_pkts[k];
                e.ch = m_chan; e.len = m_len;
                push = 1; m_collect = 0;
            end
        end
        if (pop) void'(m_fifo.pop_front());
        if (push) begin
            if (m_fifo.size() < DEPTH) m_fifo.push_back(e);
            else begin err_ev = 1; drop_ev = 1; end
        end
        if (err_ev)       m_err = 1;
        else if (err_clr) m_err = 0;
        if (drop_ev)      m_cnt = err_clr ? 1 : ((m_cnt < 255) ? m_cnt + 1 : 255);
        else if (err_clr) m_cnt = 0;
    endfunction

    function automatic bit model_af();
        int free_e = DEPTH - m_fifo.size();
        return (free_e <= AF_LVL) || ((free_e == AF_LVL + 1) && m_collect);
    endfunction

    task automatic compare_all();
        chk("valid", 128'(pay_valid), 128'(m_fifo.size() > 0));
        chk("packet_af", 128'(af), 128'(model_af()));
        chk("err", 128'(err), 128'(m_err));
        chk("drop_cnt", 128'(drop_cnt), 128'(m_cnt));
        if (m_fifo.size() > 0) begin
            chk("payload", payload, m_fifo[0].payload);
            chk("payload_ch", 128'(pay_ch), 128'(m_fifo[0].ch));
            chk("payload_len", 128'(pay_len), 128'(m_fifo[0].len));
        end
    endtask

    // One clock: the edge consumes the current inputs, outputs sampled 1ns later.
    task automatic step();
        @(posedge clk);
        #1;
        model_edge();
        compare_all();
    endtask

    task automatic do_reset();
        rst_n = 1'b0; packet = '0; err_clr = 1'b0; ready = 1'b0;
        step(); step();
        rst_n = 1'b1;
    endtask

    task automatic send_full(input int t, input int ch);
        packet = hdr(ch, 8);
        step();
        for (int k = 0; k < 8; k++) begin
            packet = data_for(t, k);
            step();
        end
        packet = '0;
    endtask

    typedef struct {
        int         ch;
        int         n;
        logic [3:0] en;
        bit         exp_push;
        bit         exp_err;
        int         exp_cnt;
    } vec_t;

    vec_t         vt[9];
    logic [127:0] exp_p;
    logic [15:0]  d;
    logic [31:0]  r;
    int           popped;

    initial begin
        vt[0] = '{0, 1,  4'hF, 1, 0, 0};
        vt[1] = '{3, 8,  4'hF, 1, 0, 0};
        vt[2] = '{2, 9,  4'hF, 0, 1, 1};
        vt[3] = '{1, 15, 4'hF, 0, 1, 1};
        vt[4] = '{1, 4,  4'hD, 0, 0, 1};
        vt[5] = '{2, 0,  4'hF, 0, 1, 0};
        vt[6] = '{0, 5,  4'hE, 0, 0, 1};
        vt[7] = '{3, 9,  4'h7, 0, 1, 1};
        vt[8] = '{2, 7,  4'h4, 1, 0, 0};

        rst_n = 1'b0; packet = '0; ch_en = 4'hF; err_clr = 1'b0; ready = 1'b0;

        // Reset state, including zeroed head fields.
        do_reset();
        chk("rst_valid", 128'(pay_valid), 128'(0));
        chk("rst_af", 128'(af), 128'(0));
        chk("rst_err", 128'(err), 128'(0));
        chk("rst_cnt", 128'(drop_cnt), 128'(0));
        chk("rst_payload", payload, 128'(0));
        chk("rst_ch", 128'(pay_ch), 128'(0));
        chk("rst_len", 128'(pay_len), 128'(0));

        // Single-header table; the enable mask is inverted during data to show
        // it only matters at decode.
        for (int i = 0; i < 9; i++) begin
            do_reset();
            ch_en = vt[i].en;
            packet = hdr(vt[i].ch, vt[i].n);
            step();
            ch_en = ~vt[i].en;
            exp_p = '0;
            for (int k = 0; k < vt[i].n; k++) begin
                d = 16'($urandom);
                packet = d;
                if (k < 8) exp_p[k*16 +: 16] = d;
                step();
            end
            packet = '0; ch_en = 4'hF;
            chk($sformatf("tbl%0d_push", i), 128'(pay_valid), 128'(vt[i].exp_push));
            chk($sformatf("tbl%0d_err", i), 128'(err), 128'(vt[i].exp_err));
            chk($sformatf("tbl%0d_cnt", i), 128'(drop_cnt), 128'(vt[i].exp_cnt));
            if (vt[i].exp_push) begin
                chk($sformatf("tbl%0d_payload", i), payload, exp_p);
                chk($sformatf("tbl%0d_ch", i), 128'(pay_ch), 128'(vt[i].ch));
                chk($sformatf("tbl%0d_len", i), 128'(pay_len), 128'(vt[i].n));
            end
        end

        // Eight-packet assembly, valid one cycle after the last data packet.
        do_reset();
        packet = hdr(1, 8);
        step();
        for (int k = 0; k < 8; k++) begin
            if (k == 7) chk("full8_not_early", 128'(pay_valid), 128'(0));
            packet = 16'(k + 1);
            step();
        end
        packet = '0;
        chk("full8_valid", 128'(pay_valid), 128'(1));
        chk("full8_payload", payload, 128'h0008_0007_0006_0005_0004_0003_0002_0001);
        chk("full8_ch", 128'(pay_ch), 128'(1));
        chk("full8_len", 128'(pay_len), 128'(8));

        // Short payload followed by a header with no idle cycle between.
        do_reset();
        packet = hdr(2, 3); step();
        packet = 16'hAAAA;  step();
        packet = 16'hBBBB;  step();
        packet = 16'hCCCC;  step();
        chk("short_payload", payload, {80'h0, 16'hCCCC, 16'hBBBB, 16'hAAAA});
        chk("short_len", 128'(pay_len), 128'(3));
        packet = hdr(0, 1); step();
        packet = 16'h1234;  step();
        packet = '0;
        ready = 1'b1; step(); ready = 1'b0;
        chk("bubble_payload", payload, {112'h0, 16'h1234});
        chk("bubble_ch", 128'(pay_ch), 128'(0));
        chk("bubble_len", 128'(pay_len), 128'(1));

        // Disabled channel drop, then a zero-length header.
        do_reset();
        ch_en = 4'h7;
        packet = hdr(3, 4); step();
        for (int k = 0; k < 4; k++) begin packet = 16'(k + 16'h50); step(); end
        packet = '0;
        chk("dis_cnt", 128'(drop_cnt), 128'(1));
        chk("dis_err", 128'(err), 128'(0));
        chk("dis_valid", 128'(pay_valid), 128'(0));
        packet = hdr(0, 0); step();
        packet = '0;
        chk("zero_err", 128'(err), 128'(1));
        chk("zero_cnt", 128'(drop_cnt), 128'(1));
        ch_en = 4'hF;

        // Overflow: five transactions into a four-deep FIFO with no reader.
        do_reset();
        for (int t = 0; t < 5; t++) begin
            send_full(t, 0);
            if (t == 1) chk("ovf_af_at2", 128'(af), 128'(0));
            if (t == 2) chk("ovf_af_at3", 128'(af), 128'(1));
        end
        chk("ovf_err", 128'(err), 128'(1));
        chk("ovf_cnt", 128'(drop_cnt), 128'(1));
        ready = 1'b1;
        for (int t = 0; t < 4; t++) begin
            chk($sformatf("ovf_drain%0d", t), payload, payload_for(t));
            step();
        end
        ready = 1'b0;
        chk("ovf_empty", 128'(pay_valid), 128'(0));

        // Full FIFO with a pop on the same edge as the completing push.
        do_reset();
        for (int t = 0; t < 4; t++) send_full(t, 2);
        packet = hdr(2, 8); step();
        for (int k = 0; k < 8; k++) begin
            packet = data_for(4, k);
            if (k == 7) ready = 1'b1;
            step();
            ready = 1'b0;
        end
        packet = '0;
        chk("samepop_err", 128'(err), 128'(0));
        chk("samepop_cnt", 128'(drop_cnt), 128'(0));
        chk("samepop_af", 128'(af), 128'(1));
        ready = 1'b1; popped = 0;
        for (int g = 0; g < 8 && pay_valid; g++) begin
            chk($sformatf("samepop_drain%0d", g), payload, payload_for(g + 1));
            step();
            popped++;
        end
        ready = 1'b0;
        chk("samepop_count", 128'(popped), 128'(4));

        // Reset in the middle of collection.
        do_reset();
        packet = hdr(1, 8); step();
        for (int k = 0; k < 4; k++) begin packet = data_for(9, k); step(); end
        packet = data_for(9, 4); rst_n = 1'b0; step();
        rst_n = 1'b1; packet = '0; step();
        chk("midrst_valid", 128'(pay_valid), 128'(0));
        send_full(7, 3);
        chk("midrst_payload", payload, payload_for(7));
        chk("midrst_ch", 128'(pay_ch), 128'(3));

        // Randomized soak against the model with drifting reader throughput.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            rst_n   = ($urandom_range(0, 499) != 0);
            err_clr = ($urandom_range(0, 39) == 0);
            ready   = ($urandom_range(0, 3) < ((c / 400) % 4));
            if ($urandom_range(0, 63) == 0) ch_en = 4'($urandom);
            r = $urandom;
            if (m_rem == 0 && $urandom_range(0, 3) != 0)
                packet = hdr($urandom_range(0, 3), $urandom_range(0, 10)) | {r[15:7], 7'b0};
            else
                packet = r[15:0];
            step();
        end
        rst_n = 1'b1; err_clr = 1'b0; ready = 1'b0; packet = '0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
